mem_port_arbiter: RTL

- Shares one single-ported 32-bit memory slave between the CPU instruction-fetch requester and the data load/store requester. Both sides use a read/write/waitrequest handshake.
- At grant, the winning request (address, write data, byte enables, direction) is latched. The memory port is then driven from those registers until the slave completes.
- Data has priority over instruction fetch. A starvation counter guarantees fetch forward progress.
- A timeout watchdog force-completes transfers to an unresponsive slave.

---
 rtl/mem_port_arbiter_if.sv | 32 +++
 rtl/mem_port_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Read/write/waitrequest bus used on both requester ports and the memory port
// of mem_port_arbiter. The master drives the request; the slave answers with
// read data and a stall.
interface mem_port_arbiter_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        output byteenable,
        input  readdata,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        input  byteenable,
        output readdata,
        output waitrequest
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-ported 32-bit memory: data beats fetch,
// a starvation counter bounds fetch latency, and a watchdog frees a hung slave.
module mem_port_arbiter #(
    parameter int DATA_BURST_MAX = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_port_arbiter_if.slave     instr_bus,
    mem_port_arbiter_if.slave     data_bus,
    mem_port_arbiter_if.master    mem_bus,
    output logic                  timeout_err,
    output logic                  proto_err
);

    localparam int SC_W = $clog2(DATA_BURST_MAX + 1);
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(DATA_BURST_MAX);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic            WDOG_EN    = (TIMEOUT_CYCLES > 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER_I = 2'd1,
        XFER_D = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              terr_q, terr_d;
    logic              perr_q, perr_d;

    logic              data_req_s;
    logic              grant_i_s;
    logic              grant_d_s;
    logic              in_xfer_s;
    logic              done_s;
    logic              force_s;
    logic              end_s;
    logic [31:0]       resp_data_s;

    // Arbitration decision and completion detection for the current cycle.
    always_comb begin
        data_req_s = data_bus.read | data_bus.write;
        grant_i_s  = 1'b0;
        grant_d_s  = 1'b0;
        if (state_q == IDLE) begin
            // Fetch only wins a contested slot once data has used its full burst.
            grant_i_s = instr_bus.read & (~data_req_s | (starve_q == STARVE_MAX));
            grant_d_s = data_req_s & ~grant_i_s;
        end else begin
            grant_i_s = 1'b0;
            grant_d_s = 1'b0;
        end

        in_xfer_s = (state_q == XFER_I) || (state_q == XFER_D);
        done_s    = in_xfer_s & ~mem_bus.waitrequest;
        force_s   = in_xfer_s & WDOG_EN & mem_bus.waitrequest & (to_cnt_q == TO_LAST);
        end_s     = done_s | force_s;

        if (done_s) begin
            resp_data_s = rd_q ? mem_bus.readdata : 32'h0000_0000;
        end else begin
            resp_data_s = 32'hFFFF_FFFF;
        end
    end

    // Next-state and latched-request logic.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        starve_d = starve_q;
        to_cnt_d = to_cnt_q;
        terr_d   = terr_q;
        perr_d   = perr_q;

        case (state_q)
            IDLE: begin
                to_cnt_d = {TO_W{1'b0}};
                if (grant_i_s) begin
                    state_d  = XFER_I;
                    addr_d   = instr_bus.address;
                    wdata_d  = 32'h0000_0000;
                    be_d     = 4'hF;
                    rd_d     = 1'b1;
                    wr_d     = 1'b0;
                    starve_d = {SC_W{1'b0}};
                end else if (grant_d_s) begin
                    state_d = XFER_D;
                    addr_d  = data_bus.address;
                    wdata_d = data_bus.writedata;
                    be_d    = data_bus.byteenable;
                    // A simultaneous read+write is resolved as a write.
                    wr_d    = data_bus.write;
                    rd_d    = ~data_bus.write;
                    perr_d  = perr_q | (data_bus.read & data_bus.write);
                    if (instr_bus.read) begin
                        if (starve_q != STARVE_MAX) begin
                            starve_d = starve_q + SC_W'(1);
                        end else begin
                            starve_d = starve_q;
                        end
                    end else begin
                        starve_d = {SC_W{1'b0}};
                    end
                end else begin
                    starve_d = {SC_W{1'b0}};
                end
            end
            XFER_I, XFER_D: begin
                if (end_s) begin
                    state_d  = IDLE;
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    to_cnt_d = {TO_W{1'b0}};
                    terr_d   = terr_q | (force_s & ~done_s);
                end else if (mem_bus.waitrequest && WDOG_EN) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end else begin
                    to_cnt_d = to_cnt_q;
                end
            end
            default: begin
                state_d  = IDLE;
                rd_d     = 1'b0;
                wr_d     = 1'b0;
                to_cnt_d = {TO_W{1'b0}};
            end
        endcase
    end

    // State and latched-request registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= 32'h0000_0000;
            wdata_q  <= 32'h0000_0000;
            be_q     <= 4'h0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            starve_q <= {SC_W{1'b0}};
            to_cnt_q <= {TO_W{1'b0}};
            terr_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            starve_q <= starve_d;
            to_cnt_q <= to_cnt_d;
            terr_q   <= terr_d;
            perr_q   <= perr_d;
        end
    end

    // Requester responses: only the owner of the finishing transfer is released.
    always_comb begin
        instr_bus.waitrequest = 1'b1;
        instr_bus.readdata    = 32'h0000_0000;
        data_bus.waitrequest  = 1'b1;
        data_bus.readdata     = 32'h0000_0000;
        case (state_q)
            XFER_I: begin
                if (end_s) begin
                    instr_bus.waitrequest = 1'b0;
                    instr_bus.readdata    = resp_data_s;
                end else begin
                    instr_bus.waitrequest = 1'b1;
                end
            end
            XFER_D: begin
                if (end_s) begin
                    data_bus.waitrequest = 1'b0;
                    data_bus.readdata    = resp_data_s;
                end else begin
                    data_bus.waitrequest = 1'b1;
                end
            end
            default: begin
                instr_bus.waitrequest = 1'b1;
                data_bus.waitrequest  = 1'b1;
            end
        endcase
    end

    // Memory side is driven purely from registers.
    always_comb begin
        mem_bus.address    = addr_q;
        mem_bus.writedata  = wdata_q;
        mem_bus.byteenable = be_q;
        mem_bus.read       = rd_q;
        mem_bus.write      = wr_q;
        timeout_err        = terr_q;
        proto_err          = perr_q;
    end

endmodule
